column_scan_sequencer: RTL and testbench
========================================

COLUMN_SCAN_SEQUENCER -- requirements
Module: column_scan_sequencer

Interface
REQ-001 The block SHALL have parameter COLUMN_NUMBER, default 3: number of matrix columns scanned per frame (>=2).
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 1000: clk cycles each column is lit (>=1).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 16: clk cycles of forced blanking before each column switch (>=1).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 4096: handshake watchdog limit, used only with the REQ-027 macro.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port run, input, 1 bit: scanning enable, level.
REQ-008 The block SHALL have port col_ready, input, 1 bit: the column shifter has its next pattern staged and accepts select_next.
REQ-009 The block SHALL have port load_done, input, 1 bit: one-cycle pulse from the pixel loader when data for load_col is shifted.
REQ-010 The block SHALL have port select_next, output, 1 bit: one-cycle pulse that latches the next column in the column shifter.
REQ-011 The block SHALL have port extra_bit, output, 1 bit: frame marker bit shifted alongside the column pattern.
REQ-012 The block SHALL have port load_req, output, 1 bit: one-cycle pulse asking the loader to shift data for load_col.
REQ-013 The block SHALL have port load_col, output, $clog2(COLUMN_NUMBER) bits: index of the column being loaded or lit.
REQ-014 The block SHALL have port blank, output, 1 bit: high means LED drivers disabled.
REQ-015 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse when column 0 is selected.
REQ-016 The block SHALL have port fault, output, 1 bit: sticky handshake-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT_READY, BLANK, SELECT and DWELL, with all outputs registered.
REQ-018 IDLE: blank=1; run=1 -> LOAD on the next cycle; run=0 -> stay.
REQ-019 LOAD: load_req=1 only in the first LOAD cycle; load_done is sampled from the second LOAD cycle on, and a pulse coincident with load_req is ignored; load_done=1 -> WAIT_READY.
REQ-020 WAIT_READY: col_ready=1 -> BLANK next cycle, including when col_ready is already high on entry; otherwise wait.
REQ-021 BLANK: blank=1 for exactly BLANK_CYCLES cycles, then -> SELECT.
REQ-022 SELECT: exactly one cycle; select_next=1; blank=1; frame_start=1 iff load_col==0; -> DWELL.
REQ-023 DWELL: blank=0 for exactly DWELL_CYCLES cycles, then load_col increments, wrapping COLUMN_NUMBER-1 -> 0; run=1 -> LOAD, run=0 -> IDLE.
REQ-024 extra_bit SHALL equal 1 while load_col==0 and 0 otherwise.
REQ-025 Deasserting run SHALL take effect only at the end of DWELL; an in-progress column always completes, and load_col is kept for the restart.
REQ-026 Counters SHALL be sized $clog2(max+1) and never wrap inside a phase.

Configuration
REQ-027 With COLUMN_SCAN_WATCHDOG_EN defined: a wait longer than TIMEOUT_CYCLES in LOAD or WAIT_READY sets fault=1 (sticky until rst), forces blank=1 and moves to IDLE, and the FSM stays in IDLE while fault=1; without the macro, waits are unbounded and fault is tied 0.

Reset
REQ-028 rst=1 on a clk edge SHALL force IDLE, load_col=0, all counters=0, blank=1, extra_bit=1, fault=0, and select_next/load_req/frame_start=0, overriding any state mid-operation.
REQ-029 The first active cycle after rst deasserts SHALL obey REQ-018.

Verification
REQ-030 COLUMN_NUMBER=3, DWELL=8, BLANK=2, loader and col_ready respond immediately, run=1 -> select_next pulses for load_col 0,1,2,0; frame_start only with col 0; blank low for exactly 8 cycles per column.
REQ-031 load_done pulsed in the same cycle as load_req -> ignored; FSM stays in LOAD until a later load_done.
REQ-032 col_ready held low 50 cycles in WAIT_READY -> no select_next and blank=1 throughout; col_ready high -> select_next exactly 3 cycles later.
REQ-033 run dropped mid-DWELL of column 1 -> column 1 finishes its 8 cycles, then IDLE with load_col=2; run re-raised -> load_req with load_col=2.
REQ-034 rst asserted in BLANK -> next cycle IDLE, load_col=0, blank=1, no select_next.
REQ-035 With the macro, TIMEOUT=20 and load_done never asserted -> fault=1 after 20 LOAD cycles, FSM in IDLE, cleared only by rst.

Source files
------------

// File: rtl/column_scan_sequencer.sv
// Column scan sequencer for a multiplexed LED matrix: load -> wait ready -> blank -> select -> dwell.
// Optional handshake watchdog enabled by defining COLUMN_SCAN_WATCHDOG_EN.
module column_scan_sequencer #(
    parameter int COLUMN_NUMBER  = 3,
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic                             col_ready,
    input  logic                             load_done,
    output logic                             select_next,
    output logic                             extra_bit,
    output logic                             load_req,
    output logic [$clog2(COLUMN_NUMBER)-1:0] load_col,
    output logic                             blank,
    output logic                             frame_start,
    output logic                             fault
);

    localparam int COL_W = $clog2(COLUMN_NUMBER);
`ifdef COLUMN_SCAN_WATCHDOG_EN
    localparam int PHASE_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > PHASE_MAX) ? TIMEOUT_CYCLES : PHASE_MAX;
`else
    localparam int CNT_MAX   = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLUMN_NUMBER - 1);
`ifdef COLUMN_SCAN_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    if (COLUMN_NUMBER < 2 || DWELL_CYCLES < 1 || BLANK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("column_scan_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_READY,
        S_BLANK,
        S_SELECT,
        S_DWELL
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [COL_W-1:0]   r_load_col;
    logic               r_select_next;
    logic               r_load_req;
    logic               r_frame_start;
    logic               r_blank;
    logic               r_extra_bit;
    logic [COL_W-1:0]   w_next_col;
    logic               w_fault_hold;

    assign w_next_col = (r_load_col == COL_LAST) ? '0 : r_load_col + COL_W'(1);

`ifdef COLUMN_SCAN_WATCHDOG_EN
    logic r_fault;
    assign w_fault_hold = r_fault;
    assign fault        = r_fault;
`else
    assign w_fault_hold = 1'b0;
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_load_col    <= '0;
            r_select_next <= 1'b0;
            r_load_req    <= 1'b0;
            r_frame_start <= 1'b0;
            r_blank       <= 1'b1;
            r_extra_bit   <= 1'b1;
`ifdef COLUMN_SCAN_WATCHDOG_EN
            r_fault       <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low here so every branch below only raises them for one cycle.
            r_select_next <= 1'b0;
            r_load_req    <= 1'b0;
            r_frame_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_blank <= 1'b1;
                    r_cnt   <= '0;
                    if (run && !w_fault_hold) begin
                        r_state    <= S_LOAD;
                        r_load_req <= 1'b1;
                    end
                end

                // r_load_req is high only during the first LOAD cycle, masking a coincident load_done.
                S_LOAD: begin
                    if (!r_load_req && load_done) begin
                        r_state <= S_WAIT_READY;
                        r_cnt   <= '0;
                    end
`ifdef COLUMN_SCAN_WATCHDOG_EN
                    else if (r_cnt == TIMEOUT_LAST) begin
                        r_fault <= 1'b1;
                        r_blank <= 1'b1;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                S_WAIT_READY: begin
                    if (col_ready) begin
                        r_state <= S_BLANK;
                        r_cnt   <= '0;
                    end
`ifdef COLUMN_SCAN_WATCHDOG_EN
                    else if (r_cnt == TIMEOUT_LAST) begin
                        r_fault <= 1'b1;
                        r_blank <= 1'b1;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end

                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state       <= S_SELECT;
                        r_cnt         <= '0;
                        r_select_next <= 1'b1;
                        r_frame_start <= (r_load_col == '0);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_SELECT: begin
                    r_state <= S_DWELL;
                    r_blank <= 1'b0;
                    r_cnt   <= '0;
                end

                // Column index advances at the end of the dwell so a paused scan resumes on the next column.
                S_DWELL: begin
                    if (r_cnt == DWELL_LAST) begin
                        r_cnt       <= '0;
                        r_blank     <= 1'b1;
                        r_load_col  <= w_next_col;
                        r_extra_bit <= (w_next_col == '0);
                        if (run) begin
                            r_state    <= S_LOAD;
                            r_load_req <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_blank <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign select_next = r_select_next;
    assign load_req    = r_load_req;
    assign frame_start = r_frame_start;
    assign blank       = r_blank;
    assign extra_bit   = r_extra_bit;
    assign load_col    = r_load_col;

endmodule

// File: tb/tb_column_scan_sequencer.sv
// Self-checking bench for column_scan_sequencer: per-column timing predicted from handshake event times.
// Define COLUMN_SCAN_WATCHDOG_EN to also exercise the watchdog.
module tb_column_scan_sequencer;

    localparam int NCOL    = 3;
    localparam int DWELL   = 8;
    localparam int BLANK   = 2;
    localparam int TIMEOUT = 20;
`ifdef COLUMN_SCAN_WATCHDOG_EN
    localparam int READY_HOLD = 15;
    localparam int RDY_MAX    = 10;
`else
    localparam int READY_HOLD = 50;
    localparam int RDY_MAX    = 30;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       col_ready;
    logic       load_done;
    logic       select_next;
    logic       extra_bit;
    logic       load_req;
    logic [1:0] load_col;
    logic       blank;
    logic       frame_start;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int exp_col  = 0;

    column_scan_sequencer #(
        .COLUMN_NUMBER (NCOL),
        .DWELL_CYCLES  (DWELL),
        .BLANK_CYCLES  (BLANK),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .col_ready  (col_ready),
        .load_done  (load_done),
        .select_next(select_next),
        .extra_bit  (extra_bit),
        .load_req   (load_req),
        .load_col   (load_col),
        .blank      (blank),
        .frame_start(frame_start),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input string ph, input bit e_sel, input bit e_fs, input bit e_blank, input bit e_req);
        check({ph, ".select_next"}, select_next, e_sel);
        check({ph, ".frame_start"}, frame_start, e_fs);
        check({ph, ".blank"},       blank,       e_blank);
        check({ph, ".load_req"},    load_req,    e_req);
        check({ph, ".load_col"},    load_col,    exp_col);
        check({ph, ".extra_bit"},   extra_bit,   exp_col == 0);
        check({ph, ".fault"},       fault,       1'b0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            expect_out("idle", 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
    endtask

    // Called in the first LOAD cycle. Times of load_done / col_ready determine when select and dwell occur.
    task automatic do_column(input int ld_delay, input int rdy_at, input bit early, input bit run_after);
        int t_req;
        int t_ld;
        int t_wait;
        int t_rdy;
        int t_sel;
        int t_end;
        t_req  = cyc;
        t_ld   = t_req + ld_delay;
        t_wait = t_ld + 1;
        t_rdy  = t_req + rdy_at;
        t_sel  = ((t_rdy > t_wait) ? t_rdy : t_wait) + BLANK + 1;
        t_end  = t_sel + DWELL;
        while (cyc <= t_end) begin
            load_done = (cyc == t_ld) || (early && cyc == t_req);
            col_ready = (cyc >= t_rdy) && (cyc <= t_sel);
            if (!run_after && cyc == t_sel + 3) run = 1'b0;
            expect_out("col", cyc == t_sel, (cyc == t_sel) && (exp_col == 0),
                       !(cyc > t_sel && cyc <= t_end), cyc == t_req);
            tick();
        end
        load_done = 1'b0;
        col_ready = 1'b0;
        exp_col   = (exp_col + 1) % NCOL;
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        col_ready = 1'b0;
        load_done = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        idle_check(3);

        // Immediate responders, col_ready already high on entry: columns 0,1,2,0.
        run = 1'b1;
        expect_out("start", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) do_column(1, 0, 1'b0, 1'b1);

        // run dropped mid-dwell of column 1: column completes, idles with load_col=2.
        do_column(1, 0, 1'b0, 1'b0);
        check("pause.load_col_kept", load_col, 2);
        idle_check(5);
        run = 1'b1;
        expect_out("restart", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // load_done coincident with load_req is ignored; the later pulse is accepted.
        do_column(4, 0, 1'b1, 1'b1);

        // col_ready held low for READY_HOLD cycles inside WAIT_READY.
        do_column(1, 2 + READY_HOLD, 1'b0, 1'b1);

        // Randomized handshake latencies and pauses; ends on a non-zero column.
        for (int i = 0; i < 12 || exp_col == 0; i++) begin
            int  ld;
            int  rdy;
            bit  early;
            bit  ra;
            ld    = $urandom_range(1, 5);
            rdy   = $urandom_range(0, RDY_MAX);
            early = 1'($urandom_range(0, 1));
            ra    = ($urandom_range(0, 3) != 0);
            do_column(ld, rdy, early, ra);
            if (!ra) begin
                idle_check($urandom_range(1, 4));
                run = 1'b1;
                expect_out("restart", 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
            end
        end

        // Reset during BLANK.
        col_ready = 1'b1;
        load_done = 1'b0;
        expect_out("rb.load", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        load_done = 1'b1;
        expect_out("rb.load2", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        load_done = 1'b0;
        expect_out("rb.wait", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("rb.blank", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        exp_col   = 0;
        run       = 1'b0;
        col_ready = 1'b0;
        expect_out("rb.reset", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        idle_check(4);

`ifdef COLUMN_SCAN_WATCHDOG_EN
        // Loader never answers: fault after TIMEOUT LOAD cycles, sticky until rst.
        run = 1'b1;
        expect_out("wd.idle", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            check("wd.fault_low", fault, 1'b0);
            check("wd.load_req", load_req, k == 0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            check("wd.fault_sticky", fault, 1'b1);
            check("wd.blank", blank, 1'b1);
            check("wd.held_idle", load_req, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        run = 1'b0;
        rst = 1'b0;
        check("wd.fault_cleared", fault, 1'b0);
        tick();
        check("wd.still_clear", fault, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
